chdr_len_enforce: RTL and testbench

- Sits directly downstream of the CHDR resizer. Checks every packet's beat count against the Length field in its CHDR header.
- Emits a well-formed packet in every case:
  - Short packets are zero-padded to the header length.
  - Long packets are truncated at the header length, and the excess input beats are discarded.
- Protects downstream crossbar/endpoint logic from malformed framing after width conversion.

---
 rtl/chdr_len_enforce.sv | 184 ++++++++++++++++++
 tb/tb_chdr_len_enforce.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chdr_len_enforce.sv
// Enforces CHDR framing: pads short packets with zero beats and truncates long ones to the header Length.
// Define CHDR_LEN_ENFORCE_STATS_EN to build the short/long packet counters; otherwise they read as zero.
module chdr_len_enforce #(
    parameter int unsigned CHDR_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CHDR_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [CHDR_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              short_pkt,
    output logic              long_pkt,
    output logic [CNT_W-1:0]  short_cnt,
    output logic [CNT_W-1:0]  long_cnt
);

    localparam int unsigned BYTES = CHDR_W / 8;
    localparam int unsigned SH    = $clog2(BYTES);
    localparam int unsigned LEN_W = 16;
    localparam int unsigned NB_W  = LEN_W + 1;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_BODY = 2'd1,
        ST_PAD  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NB_W-1:0]   r_rem;
    logic [NB_W-1:0]   w_rem_nxt;
    logic              r_short_pkt;
    logic              r_long_pkt;
    logic              w_short_set;
    logic              w_long_set;

    logic [LEN_W-1:0]  w_len;
    logic [NB_W-1:0]   w_nbeats_raw;
    logic [NB_W-1:0]   w_nbeats;
    logic              w_hdr_single;
    logic              w_rem_last;
    logic              w_in_beat;

    logic [CHDR_W-1:0] w_tdata;
    logic              w_tlast;
    logic              w_tvalid;
    logic              w_s_tready;

    // Beat count from the byte length: ceil via add-then-shift, floored at one beat.
    assign w_len        = s_axis_tdata[47:32];
    assign w_nbeats_raw = ({1'b0, w_len} + NB_W'(BYTES - 1)) >> SH;
    assign w_nbeats     = (w_nbeats_raw == '0) ? NB_W'(1) : w_nbeats_raw;
    assign w_hdr_single = (w_nbeats == NB_W'(1));
    assign w_rem_last   = (r_rem == NB_W'(1));
    assign w_in_beat    = s_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HDR;
            r_rem       <= '0;
            r_short_pkt <= 1'b0;
            r_long_pkt  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_short_pkt <= w_short_set;
            r_long_pkt  <= w_long_set;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_short_set = 1'b0;
        w_long_set  = 1'b0;
        w_tdata     = s_axis_tdata;
        w_tvalid    = s_axis_tvalid;
        w_s_tready  = m_axis_tready;
        w_tlast     = 1'b0;

        case (r_state)
            ST_HDR: begin
                w_tlast = w_hdr_single;
                if (w_in_beat) begin
                    if (w_hdr_single) begin
                        if (!s_axis_tlast) begin
                            w_state_nxt = ST_DROP;
                            w_long_set  = 1'b1;
                        end
                    end else begin
                        w_rem_nxt = w_nbeats - NB_W'(1);
                        if (s_axis_tlast) begin
                            w_state_nxt = ST_PAD;
                            w_short_set = 1'b1;
                        end else begin
                            w_state_nxt = ST_BODY;
                        end
                    end
                end
            end
            ST_BODY: begin
                w_tlast = w_rem_last;
                if (w_in_beat) begin
                    w_rem_nxt = r_rem - NB_W'(1);
                    if (w_rem_last) begin
                        if (s_axis_tlast) begin
                            w_state_nxt = ST_HDR;
                        end else begin
                            w_state_nxt = ST_DROP;
                            w_long_set  = 1'b1;
                        end
                    end else if (s_axis_tlast) begin
                        w_state_nxt = ST_PAD;
                        w_short_set = 1'b1;
                    end
                end
            end
            // Input is stalled while zero beats fill out the declared length.
            ST_PAD: begin
                w_tdata    = '0;
                w_tvalid   = 1'b1;
                w_s_tready = 1'b0;
                w_tlast    = w_rem_last;
                if (m_axis_tready) begin
                    w_rem_nxt = r_rem - NB_W'(1);
                    if (w_rem_last) begin
                        w_state_nxt = ST_HDR;
                    end
                end
            end
            ST_DROP: begin
                w_tvalid   = 1'b0;
                w_s_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_nxt = ST_HDR;
                end
            end
            default: begin
                w_state_nxt = ST_HDR;
            end
        endcase
    end

    assign m_axis_tdata  = w_tdata;
    assign m_axis_tlast  = w_tlast;
    assign m_axis_tvalid = w_tvalid;
    assign s_axis_tready = w_s_tready;
    assign short_pkt     = r_short_pkt;
    assign long_pkt      = r_long_pkt;

`ifdef CHDR_LEN_ENFORCE_STATS_EN
    logic [CNT_W-1:0] r_short_cnt;
    logic [CNT_W-1:0] r_long_cnt;

    // Counters step on the same edge the pulses assert and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_short_cnt <= '0;
            r_long_cnt  <= '0;
        end else begin
            if (w_short_set) begin
                r_short_cnt <= r_short_cnt + CNT_W'(1);
            end
            if (w_long_set) begin
                r_long_cnt <= r_long_cnt + CNT_W'(1);
            end
        end
    end

    assign short_cnt = r_short_cnt;
    assign long_cnt  = r_long_cnt;
`else
    assign short_cnt = '0;
    assign long_cnt  = '0;
`endif

endmodule

// File: tb/tb_chdr_len_enforce.sv
// Scoreboard bench for chdr_len_enforce: a 64-bit instance under random traffic plus a 256-bit instance for length boundaries.
module tb_chdr_len_enforce;

    localparam int unsigned W     = 64;
    localparam int unsigned W2    = 256;
    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     s_axis_tdata;
    logic             s_axis_tlast;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [W-1:0]     m_axis_tdata;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             short_pkt;
    logic             long_pkt;
    logic [CNT_W-1:0] short_cnt;
    logic [CNT_W-1:0] long_cnt;

    logic [W2-1:0]    s2_tdata;
    logic             s2_tlast;
    logic             s2_tvalid;
    logic             s2_tready;
    logic [W2-1:0]    m2_tdata;
    logic             m2_tlast;
    logic             m2_tvalid;
    logic             m2_tready;
    logic             s2_short_pkt;
    logic             s2_long_pkt;
    logic [CNT_W-1:0] s2_short_cnt;
    logic [CNT_W-1:0] s2_long_cnt;

    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    exp_short = 0;
    int    exp_long = 0;
    int    n_short_seen = 0;
    int    n_long_seen = 0;
    bit    rdy_rand = 1'b0;
    bit    rdy_hold = 1'b0;
    bit    vld_rand = 1'b0;

    always #5 clk = ~clk;

    chdr_len_enforce #(.CHDR_W(W), .CNT_W(CNT_W)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .short_pkt     (short_pkt),
        .long_pkt      (long_pkt),
        .short_cnt     (short_cnt),
        .long_cnt      (long_cnt)
    );

    chdr_len_enforce #(.CHDR_W(W2), .CNT_W(CNT_W)) u_dut_w256 (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s2_tdata),
        .s_axis_tlast  (s2_tlast),
        .s_axis_tvalid (s2_tvalid),
        .s_axis_tready (s2_tready),
        .m_axis_tdata  (m2_tdata),
        .m_axis_tlast  (m2_tlast),
        .m_axis_tvalid (m2_tvalid),
        .m_axis_tready (m2_tready),
        .short_pkt     (s2_short_pkt),
        .long_pkt      (s2_long_pkt),
        .short_cnt     (s2_short_cnt),
        .long_cnt      (s2_long_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] cnt_exp(input int n);
`ifdef CHDR_LEN_ENFORCE_STATS_EN
        return 64'(n);
`else
        return 64'(n * 0);
`endif
    endfunction

    // Output ready: always, random 50%, or held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_hold)      m_axis_tready = 1'b0;
            else if (rdy_rand) m_axis_tready = 1'($urandom_range(0, 1));
            else               m_axis_tready = 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every accepted output beat.
    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {63'd0, m_axis_tvalid}, 64'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk("out_data", m_axis_tdata, b.data);
                    chk("out_last", {63'd0, m_axis_tlast}, {63'd0, b.last});
                end
            end
            if (short_pkt) begin
                n_short_seen++;
                chk("pulse_overlap", {63'd0, long_pkt}, 64'd0);
            end
            if (long_pkt) n_long_seen++;
        end
    end

    task automatic send_pkt(input int len, input int nin);
        logic [63:0] beats[$];
        logic [63:0] d;
        beat_t       e;
        int          nb;
        int          tries;
        bit          fired;
        nb = (len == 0) ? 1 : (len + 7) / 8;
        for (int i = 0; i < nin; i++) begin
            d = {$urandom, $urandom};
            if (i == 0) d[47:32] = 16'(len);
            beats.push_back(d);
        end
        for (int j = 0; j < nb; j++) begin
            e.data = (j < nin) ? beats[j] : 64'd0;
            e.last = (j == nb - 1);
            exp_q.push_back(e);
        end
        if (nin < nb) exp_short++;
        if (nin > nb) exp_long++;
        @(posedge clk);
        #1;
        for (int i = 0; i < nin; i++) begin
            s_axis_tdata = beats[i];
            s_axis_tlast = (i == nin - 1);
            fired = 1'b0;
            tries = 0;
            while (!fired) begin
                s_axis_tvalid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                @(negedge clk);
                fired = s_axis_tvalid && s_axis_tready;
                @(posedge clk);
                #1;
                tries++;
                if (!fired && tries > 2000) begin
                    chk("input_stall", {63'd0, s_axis_tready}, 64'd1);
                    break;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_short_pulses"}, 64'(n_short_seen), 64'(exp_short));
        chk({tag, "_long_pulses"},  64'(n_long_seen),  64'(exp_long));
        chk({tag, "_short_cnt"},    64'(short_cnt),    cnt_exp(exp_short));
        chk({tag, "_long_cnt"},     64'(long_cnt),     cnt_exp(exp_long));
    endtask

    task automatic send256(input int len, input bit last, input bit exp_last);
        logic [W2-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        d[47:32] = 16'(len);
        @(posedge clk);
        #1;
        s2_tdata  = d;
        s2_tvalid = 1'b1;
        s2_tlast  = last;
        @(negedge clk);
        chk("w256_last",  {63'd0, m2_tlast},  {63'd0, exp_last});
        chk("w256_valid", {63'd0, m2_tvalid}, 64'd1);
        chk("w256_data",  m2_tdata[63:0],     d[63:0]);
        @(posedge clk);
        #1;
        s2_tvalid = 1'b0;
        s2_tlast  = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int nb;
        int nin;
        int kind;
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        s2_tdata = '0; s2_tlast = 1'b0; s2_tvalid = 1'b0; m2_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_tvalid",  {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_s_tready",  {63'd0, s_axis_tready}, 64'd1);
        chk("rst_short_pkt", {63'd0, short_pkt},     64'd0);
        chk("rst_long_pkt",  {63'd0, long_pkt},      64'd0);
        chk("rst_short_cnt", 64'(short_cnt),         64'd0);
        chk("rst_long_cnt",  64'(long_cnt),          64'd0);

        // 256-bit lane: 32 bytes per beat.
        send256(0,  1'b1, 1'b1);
        send256(40, 1'b0, 1'b0);
        send256(0,  1'b1, 1'b1);
        send256(32, 1'b1, 1'b1);
        send256(33, 1'b0, 1'b0);
        send256(0,  1'b1, 1'b1);

        send_pkt(24, 3);
        drain();
        check_stats("exact");
        send_pkt(24, 2);
        drain();
        check_stats("short");
        send_pkt(16, 4);
        drain();
        check_stats("long");
        send_pkt(0, 1);
        send_pkt(8, 1);
        send_pkt(9, 2);
        drain();
        check_stats("edge_len");

        rdy_rand = 1'b1;
        vld_rand = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len  = int'($urandom_range(0, 72));
            nb   = (len == 0) ? 1 : (len + 7) / 8;
            kind = int'($urandom_range(0, 2));
            if (kind == 1 && nb > 1) nin = int'($urandom_range(1, nb - 1));
            else if (kind == 2)      nin = nb + int'($urandom_range(1, 3));
            else                     nin = nb;
            send_pkt(len, nin);
        end
        drain();
        check_stats("random");

        // Reset while padding: 5-beat packet cut at 2 beats, one pad beat out, two left.
        rdy_rand = 1'b0;
        vld_rand = 1'b0;
        send_pkt(40, 2);
        @(posedge clk);
        #2;
        rdy_hold = 1'b1;
        m_axis_tready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        rdy_hold = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        chk("rstpad_pending", 64'(exp_q.size()), 64'd2);
        chk("rstpad_short_cnt", 64'(short_cnt), 64'd0);
        chk("rstpad_long_cnt",  64'(long_cnt),  64'd0);
        chk("rstpad_short_pkt", {63'd0, short_pkt}, 64'd0);
        repeat (3) begin
            chk("rstpad_no_pad", {63'd0, m_axis_tvalid}, 64'd0);
            @(negedge clk);
        end
        exp_q.delete();
        exp_short = 0;
        exp_long = 0;
        n_short_seen = 0;
        n_long_seen = 0;
        send_pkt(24, 3);
        drain();
        check_stats("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
